wishbone_slave_to_rtsnoc: RTL and testbench

WISHBONE_SLAVE_TO_RTSNOC -- requirements
Module: wishbone_slave_to_rtsnoc

---
 rtl/rtsnoc_wb_pkg.sv | 21 ++
 rtl/rtsnoc_hdr_codec.sv | 35 +++
 rtl/wishbone_slave_to_rtsnoc.sv | 183 ++++++++++++++++++
 tb/tb_wishbone_slave_to_rtsnoc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtsnoc_wb_pkg.sv
// Shared definitions for the Wishbone <-> RTSNoC bridges (slave and master side).
// Holds the payload opcode encoding, default packet size and bridge FSM states.
package rtsnoc_wb_pkg;

    localparam int unsigned PKT_SIZE = 32;
    localparam int unsigned OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_WRITE = 3'd0,
        OP_READ  = 3'd1,
        OP_INT   = 3'd2
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_DATA,
        ST_WAIT_RESP
    } state_e;

endpackage

// File: rtl/rtsnoc_hdr_codec.sv
// RTSNoC flit header codec (combinational).
// Packs the constant tx header {X_orig,Y_orig,local_orig,X_dst,Y_dst,local_dst}
// in front of the payload and splits a received flit into header and payload.
module rtsnoc_hdr_codec #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned SOC_SIZE_X        = 1,
    parameter int unsigned SOC_SIZE_Y        = 1,
    parameter int unsigned NOC_LOCAL_ADR     = 0,
    parameter int unsigned NOC_X             = 0,
    parameter int unsigned NOC_Y             = 0,
    parameter int unsigned NOC_LOCAL_ADR_TGT = 0,
    parameter int unsigned NOC_X_TGT         = 0,
    parameter int unsigned NOC_Y_TGT         = 0,
    localparam int unsigned HDR_WIDTH        = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6,
    localparam int unsigned BUS_WIDTH        = DATA_WIDTH + HDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [BUS_WIDTH-1:0]  tx_flit,
    input  logic [BUS_WIDTH-1:0]  rx_flit,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [HDR_WIDTH-1:0]  rx_hdr
);

    localparam logic [SOC_SIZE_X-1:0] X_ORIG = SOC_SIZE_X'(NOC_X);
    localparam logic [SOC_SIZE_Y-1:0] Y_ORIG = SOC_SIZE_Y'(NOC_Y);
    localparam logic [2:0]            L_ORIG = 3'(NOC_LOCAL_ADR);
    localparam logic [SOC_SIZE_X-1:0] X_DST  = SOC_SIZE_X'(NOC_X_TGT);
    localparam logic [SOC_SIZE_Y-1:0] Y_DST  = SOC_SIZE_Y'(NOC_Y_TGT);
    localparam logic [2:0]            L_DST  = 3'(NOC_LOCAL_ADR_TGT);

    assign tx_flit = {X_ORIG, Y_ORIG, L_ORIG, X_DST, Y_DST, L_DST, tx_data};
    assign rx_data = rx_flit[DATA_WIDTH-1:0];
    assign rx_hdr  = rx_flit[BUS_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/wishbone_slave_to_rtsnoc.sv
// Wishbone classic slave to RTSNoC bridge.
// Each Wishbone access becomes a command flit (plus a data flit for writes) to
// the remote bridge; reads wait for the first returned flit. Unsolicited INT
// flits raise int_o. Optional read timeout: define WB_RTSNOC_RD_TIMEOUT_EN.
module wishbone_slave_to_rtsnoc
    import rtsnoc_wb_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH     = 6,
    parameter int unsigned WB_NOC_DATA_WIDTH = 32,
    parameter int unsigned NOC_LOCAL_ADR     = 0,
    parameter int unsigned NOC_X             = 0,
    parameter int unsigned NOC_Y             = 0,
    parameter int unsigned NOC_LOCAL_ADR_TGT = 0,
    parameter int unsigned NOC_X_TGT         = 0,
    parameter int unsigned NOC_Y_TGT         = 0,
    parameter int unsigned SOC_SIZE_X        = 1,
    parameter int unsigned SOC_SIZE_Y        = 1,
    parameter int unsigned RD_TIMEOUT_CYCLES = 1024,
    localparam int unsigned NOC_BUS_SIZE     = WB_NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [3:0]                   wb_sel_i,
    input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         int_o,
    output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
    output logic                         noc_wr_o,
    output logic                         noc_rd_o,
    input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
    input  logic                         noc_wait_i,
    input  logic                         noc_nd_i
);

    localparam int unsigned DW = WB_NOC_DATA_WIDTH;
    localparam int unsigned HW = NOC_BUS_SIZE - DW;

    state_e                   state;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [DW-1:0]            dat_q;
    logic                     we_q;
    logic [DW-1:0]            tx_data;
    logic [DW-1:0]            rx_data;
    logic [HW-1:0]            rx_hdr;
    logic [DW-1:0]            cmd_word;
    logic                     req;
    logic                     rx_ready;
    logic                     unused_bits;

    rtsnoc_hdr_codec #(
        .DATA_WIDTH        (DW),
        .SOC_SIZE_X        (SOC_SIZE_X),
        .SOC_SIZE_Y        (SOC_SIZE_Y),
        .NOC_LOCAL_ADR     (NOC_LOCAL_ADR),
        .NOC_X             (NOC_X),
        .NOC_Y             (NOC_Y),
        .NOC_LOCAL_ADR_TGT (NOC_LOCAL_ADR_TGT),
        .NOC_X_TGT         (NOC_X_TGT),
        .NOC_Y_TGT         (NOC_Y_TGT)
    ) u_codec (
        .tx_data (tx_data),
        .tx_flit (noc_din_o),
        .rx_flit (noc_dout_i),
        .rx_data (rx_data),
        .rx_hdr  (rx_hdr)
    );

    // Byte selects are ignored (full-word only); the latched address is kept
    // for visibility, its value already went out in the command word.
    assign unused_bits = ^{wb_sel_i, rx_hdr, adr_q};

    // A new request is taken only once the previous termination has cleared.
    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    // The router keeps noc_nd_i up for the cycle after a pop, so skip that cycle.
    assign rx_ready = noc_nd_i & ~noc_rd_o;

`ifdef WB_RTSNOC_RD_TIMEOUT_EN
    logic        err_q;
    logic [31:0] to_cnt;
    assign wb_err_o = err_q;
`else
    assign wb_err_o = 1'b0;
`endif

    // Command word {opcode, zeros, address} for the request on the bus this cycle.
    always_comb begin
        cmd_word = '0;
        cmd_word[DW-1 -: OP_WIDTH] = wb_we_i ? OP_WRITE : OP_READ;
        cmd_word[WB_ADDR_WIDTH-1:0] = wb_adr_i;
    end

    // Bridge FSM with registered strobes, terminations and tx payload.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            tx_data  <= '0;
            noc_wr_o <= 1'b0;
            noc_rd_o <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            int_o    <= 1'b0;
`ifdef WB_RTSNOC_RD_TIMEOUT_EN
            err_q    <= 1'b0;
            to_cnt   <= '0;
`endif
        end else begin
            noc_wr_o <= 1'b0;
            noc_rd_o <= 1'b0;
            wb_ack_o <= 1'b0;
            int_o    <= 1'b0;
`ifdef WB_RTSNOC_RD_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            // Flits arriving outside a read are unsolicited: only INT matters.
            if (state != ST_WAIT_RESP && rx_ready) begin
                noc_rd_o <= 1'b1;
                if (rx_data[DW-1 -: OP_WIDTH] == OP_INT) begin
                    int_o <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        adr_q    <= wb_adr_i;
                        dat_q    <= wb_dat_i;
                        we_q     <= wb_we_i;
                        tx_data  <= cmd_word;
                        noc_wr_o <= 1'b1;
                        state    <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    if (!noc_wait_i) begin
                        if (we_q) begin
                            tx_data  <= dat_q;
                            noc_wr_o <= 1'b1;
                            state    <= ST_SEND_DATA;
                        end else begin
`ifdef WB_RTSNOC_RD_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            state  <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (!noc_wait_i) begin
                        wb_ack_o <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_WAIT_RESP: begin
                    if (rx_ready) begin
                        noc_rd_o <= 1'b1;
                        wb_dat_o <= rx_data;
                        wb_ack_o <= 1'b1;
                        state    <= ST_IDLE;
                    end
`ifdef WB_RTSNOC_RD_TIMEOUT_EN
                    else if (to_cnt == RD_TIMEOUT_CYCLES - 1) begin
                        err_q    <= 1'b1;
                        wb_dat_o <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_slave_to_rtsnoc.sv
// Self-checking bench for wishbone_slave_to_rtsnoc: a vector table of Wishbone
// transactions plus hand sequences for timeout/no-timeout, and reset.
module tb_wishbone_slave_to_rtsnoc;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int BUS = 42;
    // {X_orig=1, Y_orig=0, local_orig=3, X_dst=0, Y_dst=1, local_dst=5}
    localparam logic [9:0] TX_HDR = 10'b1_0_011_0_1_101;
    localparam logic [9:0] RX_HDR = 10'b0_1_101_1_0_011;

    logic           clk_i   = 1'b0;
    logic           rst_n_i = 1'b1;
    logic           wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [AW-1:0]  wb_adr_i = '0;
    logic [3:0]     wb_sel_i = '0;
    logic [DW-1:0]  wb_dat_i = '0;
    logic [DW-1:0]  wb_dat_o;
    logic           wb_ack_o, wb_err_o, int_o;
    logic [BUS-1:0] noc_din_o;
    logic           noc_wr_o, noc_rd_o;
    logic [BUS-1:0] noc_dout_i;
    logic           noc_wait_i = 1'b0;
    logic           noc_nd_i;

    always #5 clk_i = ~clk_i;

    wishbone_slave_to_rtsnoc #(
        .WB_ADDR_WIDTH     (AW),
        .WB_NOC_DATA_WIDTH (DW),
        .NOC_LOCAL_ADR     (3),
        .NOC_X             (1),
        .NOC_Y             (0),
        .NOC_LOCAL_ADR_TGT (5),
        .NOC_X_TGT         (0),
        .NOC_Y_TGT         (1),
        .SOC_SIZE_X        (1),
        .SOC_SIZE_Y        (1),
        .RD_TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .int_o      (int_o),
        .noc_din_o  (noc_din_o),
        .noc_wr_o   (noc_wr_o),
        .noc_rd_o   (noc_rd_o),
        .noc_dout_i (noc_dout_i),
        .noc_wait_i (noc_wait_i),
        .noc_nd_i   (noc_nd_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Router rx side: flits queued by the stimulus, popped one edge after noc_rd_o.
    logic [BUS-1:0] rx_mem [16];
    int unsigned    push_cnt = 0;
    int unsigned    pop_cnt  = 0;
    assign noc_nd_i   = (push_cnt != pop_cnt);
    assign noc_dout_i = rx_mem[pop_cnt % 16];
    always @(posedge clk_i) if (noc_rd_o && push_cnt != pop_cnt) pop_cnt <= pop_cnt + 1;

    // Output monitor, sampled on the falling edge.
    int cyc_cnt = 0, wr_cnt = 0, ack_cnt = 0, rd_cnt = 0, int_cnt = 0, err_cnt = 0;
    int b2b_rd = 0, last_ack_cyc = 0, last_err_cyc = 0;
    logic prev_rd = 1'b0;
    logic [BUS-1:0] tx_log [64];
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk_i) begin
        if (noc_wr_o) begin
            tx_log[wr_cnt % 64] <= noc_din_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (wb_ack_o) begin ack_cnt <= ack_cnt + 1; last_ack_cyc <= cyc_cnt; end
        if (wb_err_o) begin err_cnt <= err_cnt + 1; last_err_cyc <= cyc_cnt; end
        if (noc_rd_o) rd_cnt <= rd_cnt + 1;
        if (int_o) int_cnt <= int_cnt + 1;
        if (noc_rd_o && prev_rd) b2b_rd <= b2b_rd + 1;
        prev_rd <= noc_rd_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_flit(input logic [BUS-1:0] f);
        rx_mem[push_cnt % 16] = f;
        push_cnt = push_cnt + 1;
    endtask

    // Results of the last run_txn call.
    int t_first, t_lat, t_wr, t_ack, t_rd, t_int, t_err, t_wr_in_wait;
    logic t_timeout;

    // One Wishbone access; returns once ack/err is seen or the budget runs out.
    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input int wait_cyc, input int resp_delay, input logic [DW-1:0] resp,
                           input logic drop, input logic side_en, input logic [DW-1:0] side_flit,
                           input int budget);
        int req_edge, k, n, wr0, ack0, rd0, int0, err0;
        step();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = 4'hF;
        if (side_en) push_flit({RX_HDR, side_flit});
        req_edge = cyc_cnt + 1;
        wr0 = wr_cnt; ack0 = ack_cnt; rd0 = rd_cnt; int0 = int_cnt; err0 = err_cnt;
        t_first = wr_cnt;
        t_wr_in_wait = 0;
        n = 0;
        do begin
            step();
            n++;
            k = cyc_cnt - req_edge;
            if (drop) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
            if (noc_wait_i) t_wr_in_wait = wr_cnt - wr0;
            noc_wait_i = (k < wait_cyc);
            if (!we && resp_delay > 0 && k == resp_delay) push_flit({RX_HDR, resp});
        end while (ack_cnt == ack0 && err_cnt == err0 && n < budget);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; noc_wait_i = 1'b0;
        t_timeout = (ack_cnt == ack0 && err_cnt == err0);
        t_lat = (err_cnt != err0) ? last_err_cyc - req_edge : last_ack_cyc - req_edge;
        t_wr  = wr_cnt - wr0;
        t_ack = ack_cnt - ack0;
        t_rd  = rd_cnt - rd0;
        t_int = int_cnt - int0;
        t_err = err_cnt - err0;
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic [31:0] dat;
        int          wait_cyc;
        int          resp_delay;
        logic [31:0] resp;
        logic        drop;
        logic        side_en;
        logic [31:0] side_flit;
        logic [31:0] exp_cmd;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
        int          exp_int;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int wr_snap, ack_snap, ack0, n;

        vecs[0] = '{1'b1, 6'h05, 32'hA5A5_0001, 0, 0,  32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0005, 32'hA5A5_0001, 2,  2, 0, 0};
        vecs[1] = '{1'b0, 6'h3F, 32'h0,         0, 10, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         32'h2000_003F, 32'h1234_5678, 11, 1, 1, 0};
        vecs[2] = '{1'b1, 6'h3F, 32'hFFFF_FFFF, 5, 0,  32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_003F, 32'hFFFF_FFFF, 7,  2, 0, 0};
        vecs[3] = '{1'b1, 6'h2A, 32'h0BAD_CAFE, 0, 0,  32'h0,         1'b0, 1'b1, 32'h4000_0000, 32'h0000_002A, 32'h0BAD_CAFE, 2,  2, 1, 1};
        vecs[4] = '{1'b0, 6'h00, 32'h0,         0, 1,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         32'h2000_0000, 32'hDEAD_BEEF, 2,  1, 1, 0};
        vecs[5] = '{1'b1, 6'h11, 32'h1357_9BDF, 0, 0,  32'h0,         1'b1, 1'b0, 32'h0,         32'h0000_0011, 32'h1357_9BDF, 2,  2, 0, 0};
        vecs[6] = '{1'b1, 6'h00, 32'h0,         0, 0,  32'h0,         1'b0, 1'b1, 32'h2000_0007, 32'h0000_0000, 32'h0000_0000, 2,  2, 1, 0};
        vecs[7] = '{1'b0, 6'h15, 32'h0,         3, 6,  32'h8000_0001, 1'b0, 1'b0, 32'h0,         32'h2000_0015, 32'h8000_0001, 7,  1, 1, 0};

        // Reset state
        #2 rst_n_i = 1'b0;
        step();
        step();
        chk("rst wb_ack_o", wb_ack_o, 0);
        chk("rst wb_err_o", wb_err_o, 0);
        chk("rst int_o", int_o, 0);
        chk("rst noc_wr_o", noc_wr_o, 0);
        chk("rst noc_rd_o", noc_rd_o, 0);
        chk("rst wb_dat_o", wb_dat_o, 0);
        chk("rst noc_din_o", noc_din_o, {TX_HDR, 32'h0});
        rst_n_i = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].wait_cyc, vecs[i].resp_delay,
                    vecs[i].resp, vecs[i].drop, vecs[i].side_en, vecs[i].side_flit, 60);
            chk($sformatf("v%0d ack_timeout", i), t_timeout, 0);
            chk($sformatf("v%0d cmd_flit", i), tx_log[t_first % 64], {TX_HDR, vecs[i].exp_cmd});
            if (vecs[i].we)
                chk($sformatf("v%0d data_flit", i), tx_log[(t_first + 1) % 64], {TX_HDR, vecs[i].exp_data});
            else
                chk($sformatf("v%0d wb_dat_o", i), wb_dat_o, vecs[i].exp_data);
            chk($sformatf("v%0d ack_latency", i), t_lat, vecs[i].exp_lat);
            chk($sformatf("v%0d wr_pulses", i), t_wr, vecs[i].exp_wr);
            chk($sformatf("v%0d ack_pulses", i), t_ack, 1);
            chk($sformatf("v%0d rd_pulses", i), t_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d int_pulses", i), t_int, vecs[i].exp_int);
            chk($sformatf("v%0d err_pulses", i), t_err, 0);
            if (vecs[i].wait_cyc > 0)
                chk($sformatf("v%0d wr_while_wait", i), t_wr_in_wait, 1);
        end

        // Read with no response from the remote bridge
`ifdef WB_RTSNOC_RD_TIMEOUT_EN
        run_txn(1'b0, 6'h07, 32'h0, 0, -1, 32'h0, 1'b0, 1'b0, 32'h0, 40);
        chk("to bound_expired", t_timeout, 0);
        chk("to err_pulses", t_err, 1);
        chk("to ack_pulses", t_ack, 0);
        chk("to err_latency", t_lat, 17);
        chk("to wb_dat_o", wb_dat_o, 0);
        step();
        chk("to err_one_cycle", wb_err_o, 0);
`else
        run_txn(1'b0, 6'h07, 32'h0, 0, -1, 32'h0, 1'b0, 1'b0, 32'h0, 40);
        chk("nto still_waiting", t_timeout, 1);
        chk("nto err_pulses", t_err, 0);
        push_flit({RX_HDR, 32'hCAFE_F00D});
        ack0 = ack_cnt;
        n = 0;
        do begin
            step();
            n++;
        end while (ack_cnt == ack0 && n < 5);
        chk("nto late_ack", ack_cnt - ack0, 1);
        chk("nto wb_dat_o", wb_dat_o, 32'hCAFE_F00D);
`endif

        // Reset while a read ack is on the bus
        run_txn(1'b0, 6'h01, 32'h0, 0, 2, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 30);
        chk("rst1 ack_seen", t_ack, 1);
        rst_n_i = 1'b0;
        #1;
        chk("rst1 wb_ack_o", wb_ack_o, 0);
        chk("rst1 wb_dat_o", wb_dat_o, 0);
        step();
        rst_n_i = 1'b1;
        step();

        // Reset mid-write, right after the command flit
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 6'h09; wb_dat_i = 32'h7777_0000;
        step();
        chk("rst2 cmd_wr", noc_wr_o, 1);
        wr_snap = wr_cnt;
        ack_snap = ack_cnt;
        rst_n_i = 1'b0;
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("rst2 noc_wr_o", noc_wr_o, 0);
        chk("rst2 wb_ack_o", wb_ack_o, 0);
        chk("rst2 noc_din_o", noc_din_o, {TX_HDR, 32'h0});
        step();
        step();
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rst2 no_more_flits", wr_cnt - wr_snap, 0);
        chk("rst2 no_ack", ack_cnt - ack_snap, 0);

        chk("rd_back_to_back", b2b_rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
